// File: rtl/snn_pkg.sv
// Shared definitions for the spike-rate decoder.
// Holds the FSM state encodings, default widths and the "no ISI" sentinel.
// No ports (package).
package snn_pkg;

  localparam int unsigned WIN_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  // Reported ISI when a window held fewer than two spikes.
  localparam logic [CNT_W_DEF-1:0] ISI_NONE_DEF = '1;

  // FSM states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

endpackage

// File: rtl/isi_tracker.sv
// Minimum inter-spike interval tracker for one acquisition window.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   clear   - start of a new window: forget previous spike, reset min_gap
//   spike   - spike qualified by the caller (only while counting)
//   min_gap - smallest gap so far INCLUDING this cycle's spike (next-state
//             view), so the caller can register a window that ends on a spike
module isi_tracker
  import snn_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             spike,
  output logic [CNT_W-1:0] min_gap
);

  localparam logic [CNT_W-1:0] GAP_MAX = '1;

  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] min_gap_q, min_gap_d;
  logic             has_prev_q, has_prev_d;

  // Gap counter restarts at 1 on a spike so back-to-back spikes measure 1.
  always_comb begin
    gap_d      = gap_q;
    min_gap_d  = min_gap_q;
    has_prev_d = has_prev_q;
    if (clear) begin
      gap_d      = '0;
      min_gap_d  = GAP_MAX;
      has_prev_d = 1'b0;
    end else if (spike) begin
      if (has_prev_q && (gap_q < min_gap_q)) begin
        min_gap_d = gap_q;
      end
      gap_d      = CNT_W'(1);
      has_prev_d = 1'b1;
    end else if (has_prev_q && (gap_q != GAP_MAX)) begin
      gap_d = gap_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q      <= '0;
      min_gap_q  <= GAP_MAX;
      has_prev_q <= 1'b0;
    end else begin
      gap_q      <= gap_d;
      min_gap_q  <= min_gap_d;
      has_prev_q <= has_prev_d;
    end
  end

  assign min_gap = min_gap_d;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes over a programmable window and reports
// the count plus minimum inter-spike interval on a valid/ready port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   en                  - enable window acquisition
//   spike               - spike pulse from the LIF neuron
//   win_len             - window length in cycles, captured at window start
//   count_out, isi_min  - result of the last completed window
//   valid, ready        - result handshake
//   busy                - high while counting
//   overrun             - sticky: spike seen with en=1 while not counting
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W-1:0] isi_min,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d, spk_cnt_inc;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic [CNT_W-1:0] isi_min_q, isi_min_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             trk_clear;
  logic             trk_spike;
  logic [CNT_W-1:0] trk_min_gap;

  // Tracker only sees spikes that fall inside a window.
  assign trk_spike = spike & (state_q == S_COUNT);

  isi_tracker #(
    .CNT_W(CNT_W)
  ) u_isi_tracker (
    .clk    (clk),
    .rst    (rst),
    .clear  (trk_clear),
    .spike  (trk_spike),
    .min_gap(trk_min_gap)
  );

  // Saturating spike count including this cycle's spike.
  assign spk_cnt_inc = (spike && (spk_cnt_q != CNT_MAX)) ? spk_cnt_q + CNT_W'(1)
                                                         : spk_cnt_q;

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    spk_cnt_d   = spk_cnt_q;
    count_out_d = count_out_q;
    isi_min_d   = isi_min_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q | (spike & en & (state_q != S_COUNT));
    trk_clear   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && (win_len != '0)) begin
          cyc_d     = win_len;
          spk_cnt_d = '0;
          trk_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!en) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          spk_cnt_d = spk_cnt_inc;
          cyc_d     = cyc_q - WIN_W'(1);
          // Last window cycle: its spike is folded into the result.
          if (cyc_q == WIN_W'(1)) begin
            count_out_d = spk_cnt_inc;
            isi_min_d   = trk_min_gap;
            valid_d     = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      spk_cnt_q   <= '0;
      count_out_q <= '0;
      isi_min_q   <= '1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      spk_cnt_q   <= spk_cnt_d;
      count_out_q <= count_out_d;
      isi_min_q   <= isi_min_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign count_out = count_out_q;
  assign isi_min   = isi_min_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: a default-width instance and a
// CNT_W=4 instance for saturation runs.
module tb_spike_rate_decoder;
  import snn_pkg::*;

  logic       clk;
  logic       rst;

  logic       en, spike, ready, valid, busy, overrun;
  logic [7:0] win_len, count_out, isi_min;

  logic       s_en, s_spike, s_ready, s_valid, s_busy, s_overrun;
  logic [7:0] s_win_len;
  logic [3:0] s_count_out, s_isi_min;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cnt;
    int isi;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t cur_m, cur_s;
  bit   seen_m = 0, seen_s = 0, have_m = 0, have_s = 0;

  spike_rate_decoder u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .spike    (spike),
    .win_len  (win_len),
    .count_out(count_out),
    .isi_min  (isi_min),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  spike_rate_decoder #(
    .WIN_W(8),
    .CNT_W(4)
  ) u_sat (
    .clk      (clk),
    .rst      (rst),
    .en       (s_en),
    .spike    (s_spike),
    .win_len  (s_win_len),
    .count_out(s_count_out),
    .isi_min  (s_isi_min),
    .valid    (s_valid),
    .ready    (s_ready),
    .busy     (s_busy),
    .overrun  (s_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main-instance monitor: pop on valid rise, compare every held cycle.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (!seen_m) begin
        seen_m = 1;
        if (q_m.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL main_unexpected_valid: got valid=1 count=%0d required no result", count_out);
          have_m = 0;
        end else begin
          cur_m  = q_m.pop_front();
          have_m = 1;
        end
      end
      if (have_m) begin
        check("main_count_out", 32'(count_out), 32'(cur_m.cnt));
        check("main_isi_min", 32'(isi_min), 32'(cur_m.isi));
      end
    end else begin
      seen_m = 0;
    end
  end

  // Saturation-instance monitor.
  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      if (!seen_s) begin
        seen_s = 1;
        if (q_s.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sat_unexpected_valid: got valid=1 count=%0d required no result", s_count_out);
          have_s = 0;
        end else begin
          cur_s  = q_s.pop_front();
          have_s = 1;
        end
      end
      if (have_s) begin
        check("sat_count_out", 32'(s_count_out), 32'(cur_s.cnt));
        check("sat_isi_min", 32'(s_isi_min), 32'(cur_s.isi));
      end
    end else begin
      seen_s = 0;
    end
  end

  // One full window on the main instance; returns in HOLD with en=0.
  task automatic run_main(input int wl, input logic [255:0] pat, input int cnt, input int isi);
    exp_t e;
    e.cnt = cnt;
    e.isi = isi;
    q_m.push_back(e);
    win_len = 8'(wl);
    en      = 1'b1;
    spike   = 1'b0;
    tick();
    check("win_start_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= wl; k++) begin
      spike = pat[k];
      tick();
    end
    spike = 1'b0;
    en    = 1'b0;
    check("valid_latency", 32'(valid), 32'd1);
    check("busy_at_result", 32'(busy), 32'd0);
  endtask

  task automatic run_sat(input logic [255:0] pat, input int cnt, input int isi);
    exp_t e;
    e.cnt = cnt;
    e.isi = isi;
    q_s.push_back(e);
    s_win_len = 8'd255;
    s_en      = 1'b1;
    s_spike   = 1'b0;
    tick();
    for (int k = 1; k <= 255; k++) begin
      s_spike = pat[k];
      tick();
    end
    s_spike = 1'b0;
    s_en    = 1'b0;
    check("sat_valid_latency", 32'(s_valid), 32'd1);
    tick();
    check("sat_valid_drop", 32'(s_valid), 32'd0);
  endtask

  initial begin
    logic [255:0] p;
    rst = 1'b1; en = 1'b0; spike = 1'b0; ready = 1'b0; win_len = 8'd0;
    s_en = 1'b0; s_spike = 1'b0; s_ready = 1'b1; s_win_len = 8'd0;

    // Reset then idle with spikes toggling
    for (int i = 0; i < 2; i++) begin
      spike = ~spike;
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spike = ~spike;
      tick();
      check("idle_count", 32'(count_out), 32'd0);
      check("idle_isi", 32'(isi_min), 32'(ISI_NONE_DEF));
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_overrun", 32'(overrun), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    spike = 1'b0;

    // Basic window: spikes on 2,5,6,9 of 10
    ready = 1'b1;
    p = '0; p[2] = 1'b1; p[5] = 1'b1; p[6] = 1'b1; p[9] = 1'b1;
    run_main(10, p, 4, 1);
    tick();
    check("basic_valid_one_cycle", 32'(valid), 32'd0);

    // Single spike on the last window cycle
    p = '0; p[4] = 1'b1;
    run_main(4, p, 1, 255);
    tick();
    check("single_valid_one_cycle", 32'(valid), 32'd0);
    check("single_overrun", 32'(overrun), 32'd0);

    // Backpressure: result held while spikes keep arriving
    ready = 1'b0;
    p = '0; p[1] = 1'b1; p[3] = 1'b1;
    run_main(5, p, 2, 2);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spike = ~spike;
      tick();
      check("bp_valid_held", 32'(valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd0);
    end
    check("bp_overrun", 32'(overrun), 32'd1);
    spike = 1'b0;
    ready = 1'b1;
    tick();
    check("bp_valid_drop", 32'(valid), 32'd0);
    check("bp_dead_cycle_busy", 32'(busy), 32'd0);
    tick();
    check("bp_restart_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick();
    check("bp_abort_busy", 32'(busy), 32'd0);

    // Abort with en=0 mid-window
    win_len = 8'd10;
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      spike = 1'b1;
      tick();
    end
    spike = 1'b0;
    en = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_valid", 32'(valid), 32'd0);
    check("abort_count_kept", 32'(count_out), 32'd2);
    check("abort_isi_kept", 32'(isi_min), 32'd2);

    // Reset mid-window
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      spike = 1'b1;
      tick();
    end
    spike = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_isi", 32'(isi_min), 32'd255);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    en = 1'b0;
    tick();

    // Zero-length window keeps the block idle
    win_len = 8'd0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wl0_busy", 32'(busy), 32'd0);
    end
    check("wl0_valid", 32'(valid), 32'd0);
    en = 1'b0;

    // Saturation on the CNT_W=4 instance
    p = '1;
    run_sat(p, 15, 1);
    p = '0; p[1] = 1'b1; p[40] = 1'b1;
    run_sat(p, 2, 15);
    check("sat_overrun", 32'(s_overrun), 32'd0);

    for (int i = 0; i < 4; i++) tick();
    check("main_queue_empty", 32'(q_m.size()), 32'd0);
    check("sat_queue_empty", 32'(q_s.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
